// File: rtl/rom_prefetch_buffer.sv
// rom_prefetch_buffer: sequential flash prefetch window serving cartridge ROM reads.
// Define ROM_PREFETCH_BACKWARD_HIT_EN to keep two bytes behind the last hit.
module rom_prefetch_buffer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data,
  output logic                 rd_wait,
  output logic                 fl_start,
  output logic                 fl_stop,
  output logic [ADDR_BITS-1:0] fl_addr,
  output logic                 fl_stall,
  input  logic [7:0]           fl_data,
  input  logic                 fl_ready,
  input  logic                 fl_busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

`ifdef ROM_PREFETCH_BACKWARD_HIT_EN
  localparam logic [ADDR_BITS-1:0] KEEP = ADDR_BITS'(2);
`else
  localparam logic [ADDR_BITS-1:0] KEEP = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_STOP,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 last_max_q, last_max_d;
  logic [ADDR_BITS-1:0] fl_addr_q, fl_addr_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [7:0]           mem_q [DEPTH];

  logic [ADDR_BITS-1:0] off;
  logic [ADDR_BITS-1:0] cnt_a;
  logic [ADDR_BITS-1:0] tail_addr;
  logic [ADDR_BITS-1:0] drop;
  logic                 streaming;
  logic                 hit;
  logic                 pend;
  logic                 miss;
  logic                 full;
  logic                 stall;
  logic                 accept;
  logic                 go_start;

  assign off       = rd_addr - base_q;
  assign cnt_a     = ADDR_BITS'(count_q);
  assign tail_addr = base_q + cnt_a;
  assign streaming = (state_q == S_STREAM);
  assign hit       = rd_req && (off < cnt_a);
  // Next sequential byte is on its way: wait for it instead of restarting
  assign pend      = rd_req && streaming && (off == cnt_a)
                     && !last_max_q && fl_busy;
  assign miss      = rd_req && !hit && !pend;
  assign full      = (count_q == CW'(DEPTH));
  assign stall     = full || last_max_q || !streaming;
  assign accept    = fl_ready && !fl_stall;
  assign drop      = (off > KEEP) ? (off - KEEP) : '0;

  assign rd_wait  = !reset && rd_req && !hit;
  assign fl_stall = reset || stall;
  assign fl_start = !reset && (state_q == S_START);
  assign fl_stop  = !reset && (state_q == S_STOP);
  assign fl_addr  = fl_addr_q;
  assign rd_data  = rd_data_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    last_max_d = last_max_q;
    fl_addr_d  = fl_addr_q;
    rd_data_d  = rd_data_q;
    go_start   = 1'b0;

    if (hit || pend) begin
      base_d  = base_q + drop;
      count_d = count_q - CW'(drop);
    end
    if (accept) begin
      count_d    = count_d + CW'(1);
      last_max_d = &tail_addr;
    end

    if (hit) begin
      rd_data_d = mem_q[rd_addr[IW-1:0]];
    end else if (accept && rd_req && (rd_addr == tail_addr)) begin
      rd_data_d = fl_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (miss) go_start = 1'b1;
      end
      S_START: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (miss) begin
          if (fl_busy) state_d = S_STOP;
          else go_start = 1'b1;
        end
      end
      S_STOP: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!fl_busy) begin
          if (miss) go_start = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_start) begin
      state_d    = S_START;
      base_d     = rd_addr;
      count_d    = '0;
      last_max_d = 1'b0;
      fl_addr_d  = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      last_max_q <= 1'b0;
      fl_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      last_max_q <= last_max_d;
      fl_addr_q  <= fl_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Entries are indexed by address low bits, so dropping never moves data
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[tail_addr[IW-1:0]] <= fl_data;
    end
  end

endmodule

// File: doc/rom_prefetch_buffer.md
# rom_prefetch_buffer

Sequential prefetch buffer between the QSPI flash controller and the Atari 2600 cartridge ROM port. It keeps a small window of consecutive ROM bytes streamed from flash and answers CPU ROM reads from that window in one cycle. On a hit, `rd_wait` stays low. On a miss, it stalls the system (`rd_wait` feeds the system-enable gating) while it stops the current flash stream and restarts it at the missed address.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; power of two, ≥4.
- `ADDR_BITS`, 12: cartridge address width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rd_req`  in  1  valid ROM address on bus this cycle.
- `rd_addr`  in  ADDR_BITS  requested ROM address.
- `rd_data`  out  8  registered read data.
- `rd_wait`  out  1  combinational stall; high while `rd_req` cannot be served this cycle.
- `fl_start`  out  1  one-cycle pulse; begin flash stream at `fl_addr`.
- `fl_stop`  out  1  one-cycle pulse; abort current flash stream.
- `fl_addr`  out  ADDR_BITS  stream start address; held stable from `fl_start` onward.
- `fl_stall`  out  1  hold the controller; no byte accepted.
- `fl_data`  in  8  streamed byte.
- `fl_ready`  in  1  `fl_data` valid; the byte is accepted when `fl_ready && !fl_stall`.
- `fl_busy`  in  1  controller has an open transaction.

## Operation
- State: `base` (ADDR_BITS), `count` (0..DEPTH), circular data store, FSM.
- Window covers `base .. base+count-1`. All arithmetic is mod 2^ADDR_BITS.
- Hit: `rd_req` and `rd_addr` is in the window.
  - `rd_data` <= entry.
  - Entries older than `rd_addr - KEEP` are dropped: `base` and `count` are adjusted by the same amount.
  - `KEEP` = 0, or 2 with the configuration macro (see Configuration).
- Pending: `rd_req`, `rd_addr == base+count`, FSM in STREAM. No restart; `rd_wait` stays high until the byte lands.
- Miss: any other `rd_req`.
- Append: an accepted byte is written at `base+count`, then `count++`.
- `fl_stall` is high when any of these holds:
  - `count == DEPTH`
  - the last appended address is the maximum address (2^ADDR_BITS - 1); no wrap into the next bank
  - FSM is not in STREAM
- FSM states:
  - IDLE: a miss leads to START.
  - START: `fl_start=1`, `fl_addr=rd_addr`, `base=rd_addr`, `count=0`; next state STREAM.
  - STREAM: a miss while `fl_busy` leads to STOP; a miss while `!fl_busy` leads to START.
  - STOP: `fl_stop=1` for one cycle, then DRAIN.
  - DRAIN: wait for `!fl_busy`, then START using the current `rd_addr`.
- Bytes arriving in STOP or DRAIN are discarded.
- Simultaneous hit-consume and append in the same cycle: both apply. Net `count = count - dropped + 1`, and it never exceeds DEPTH.
- Reset mid-stream: the FSM returns to IDLE without pulsing `fl_stop`. The controller is reset by the same reset.

## Timing
- Reset values: `rd_data=0`, `fl_start=0`, `fl_stop=0`, `fl_addr=0`, `fl_stall=1`, `count=0`, FSM=IDLE. `rd_wait=0` while `reset` is high.
- Hit latency: `rd_data` is valid on the cycle after `rd_req`, with `rd_wait` low in the request cycle.
- Miss from IDLE or from a finished stream: `fl_start` asserts on the cycle after the miss. The byte is served the cycle after its `fl_ready` is accepted.
- Miss while busy: 1 cycle STOP, plus N cycles until `fl_busy` falls, plus 1 cycle START, plus flash latency.
- `rd_wait` depends only on the current `rd_req`/`rd_addr` and registered state; it has no path from `fl_data`.
- `fl_start` and `fl_stop` are never high in the same cycle.

## Configuration
- `ROM_PREFETCH_BACKWARD_HIT_EN` defined: `KEEP=2`.
  - Up to two bytes behind the last hit stay resident, so short backward branches hit.
  - Forward prefetch capacity becomes DEPTH-2.
- Undefined: `KEEP=0`. Any address below `base` is a miss.

## Test plan
- Reset, then `rd_req` at 0x100 with flash idle -> `fl_start` with `fl_addr=0x100` the next cycle. Flash returns 0xA9 -> `rd_data=0xA9` one cycle after acceptance.
- Stream from 0x200 with DEPTH=4 and no reads -> exactly 4 bytes accepted, then `fl_stall=1`. Read 0x201 -> hit, 1-cycle latency, one new byte accepted.
- Read 0x204 while the window is 0x200..0x203 and streaming -> pending, no `fl_stop`, served when byte 0x204 lands.
- Read 0x050 during a stream at 0x300 -> `fl_stop` pulse, wait for `!fl_busy`, then `fl_start` with `fl_addr=0x050`. Late bytes from 0x300 are discarded.
- Stream from 0xFFE -> only 0xFFE and 0xFFF are appended, then `fl_stall` holds. Read 0x000 -> miss and restart.
- With the macro: hit 0x402, then read 0x400 -> hit. Without the macro: read 0x400 -> miss.
